// File: rtl/fgyrus_pcm_fetch_if.sv
// Bundle for the PCM buffer read port and the sample stream toward the FFT input stage.
// master = fetch block, slave = memory/consumer side.
interface fgyrus_pcm_fetch_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] fgyrus2acortex_addr;
   logic [DATA_W-1:0] acortex2fgyrus_pcm_data;
   logic              pcm_valid;
   logic              pcm_ready;
   logic [DATA_W-1:0] pcm_data;
   logic              pcm_lchnl;
   logic              pcm_sop;
   logic              pcm_eop;

   modport master (
      output fgyrus2acortex_addr,
      input  acortex2fgyrus_pcm_data,
      output pcm_valid,
      input  pcm_ready,
      output pcm_data,
      output pcm_lchnl,
      output pcm_sop,
      output pcm_eop
   );

   modport slave (
      input  fgyrus2acortex_addr,
      output acortex2fgyrus_pcm_data,
      input  pcm_valid,
      output pcm_ready,
      input  pcm_data,
      input  pcm_lchnl,
      input  pcm_sop,
      input  pcm_eop
   );
endinterface

// File: rtl/fgyrus_pcm_fetch.sv
// Fetches one L/R-interleaved PCM frame from the acortex buffer when the
// (asynchronous) frame-ready level rises, and streams it out through a small
// credit-managed skid FIFO.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a synchronised rdy edge with fetch_en high
// S_FETCH | issuing one read per cycle while credit is available
// S_DRAIN | all reads issued; waiting for tag pipe and FIFO to empty
module fgyrus_pcm_fetch #(
   parameter int PCM_MEM_DATA_W = 32,
   parameter int PCM_MEM_ADDR_W = 8,
   parameter int NUM_SAMPLES    = 128,
   parameter int RD_LATENCY     = 2,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                fgyrus_clk,
   input  logic                fgyrus_rst_n,
   input  logic                fetch_en,
   input  logic                acortex2fgyrus_pcm_rdy,
   fgyrus_pcm_fetch_if.master  pcm_if,
   output logic                busy,
   output logic [15:0]         frame_cnt,
   output logic                overrun,
   input  logic                overrun_clr
);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = PCM_MEM_DATA_W + 3;
   localparam logic [PCM_MEM_ADDR_W-1:0] LAST_ADDR = PCM_MEM_ADDR_W'(2 * NUM_SAMPLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

   state_t                    state_q;
   logic [PCM_MEM_ADDR_W-1:0] addr_q;
   logic [PCM_MEM_ADDR_W-1:0] next_idx_q;
   logic                      busy_q;
   logic [15:0]               frame_cnt_q, frame_cnt_d;
   logic                      overrun_q, overrun_d;

   logic       rdy_s1_q, rdy_s2_q, rdy_s3_q;
   logic [1:0] sync_vld_q;
   logic       rdy_armed_q;
   logic       rdy_pulse;

   logic [3:0]         tag_q [RD_LATENCY];
   logic [3:0]         issue_tag;
   logic [7:0]         in_flight;
   logic               credit_ok;
   logic               issue;
   logic               drained;
   logic               frame_done;

   logic [ENTRY_W-1:0] fifo_q [FIFO_DEPTH];
   logic [ENTRY_W-1:0] head;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   fifo_cnt_q;
   logic               push, pop, fifo_empty;

   // rdy synchroniser + edge detect; sync_vld_q keeps the reset value of the
   // flops from masquerading as a sampled low, so a level still high across
   // reset cannot start a frame until it has been seen low.
   always_ff @(posedge fgyrus_clk or negedge fgyrus_rst_n) begin
      if (!fgyrus_rst_n) begin
         rdy_s1_q    <= 1'b0;
         rdy_s2_q    <= 1'b0;
         rdy_s3_q    <= 1'b0;
         sync_vld_q  <= '0;
         rdy_armed_q <= 1'b0;
      end else begin
         rdy_s1_q   <= acortex2fgyrus_pcm_rdy;
         rdy_s2_q   <= rdy_s1_q;
         rdy_s3_q   <= rdy_s2_q;
         sync_vld_q <= {sync_vld_q[0], 1'b1};
         if (sync_vld_q[1] && !rdy_s2_q)
            rdy_armed_q <= 1'b1;
      end
   end

   assign rdy_pulse = rdy_s2_q & ~rdy_s3_q & rdy_armed_q;

   // Credit: reads in the tag pipe plus words parked in the FIFO never exceed the FIFO depth.
   always_comb begin
      in_flight = '0;
      for (int i = 0; i < RD_LATENCY; i++)
         in_flight = in_flight + 8'(tag_q[i][3]);
   end

   assign fifo_empty = (fifo_cnt_q == '0);
   assign credit_ok  = (in_flight + 8'(fifo_cnt_q)) < 8'(FIFO_DEPTH);
   assign issue      = (state_q == S_FETCH) && credit_ok;
   assign drained    = (in_flight == '0) && fifo_empty;
   assign frame_done = (state_q == S_DRAIN) && drained;
   assign issue_tag  = {1'b1, ~next_idx_q[0], (next_idx_q == '0), (next_idx_q == LAST_ADDR)};

   // Sequencer: walks the address space once per accepted frame.
   always_ff @(posedge fgyrus_clk or negedge fgyrus_rst_n) begin
      if (!fgyrus_rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         next_idx_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (rdy_pulse && fetch_en) begin
                  state_q    <= S_FETCH;
                  next_idx_q <= '0;
                  busy_q     <= 1'b1;
               end
            end
            S_FETCH: begin
               if (credit_ok) begin
                  addr_q     <= next_idx_q;
                  next_idx_q <= next_idx_q + PCM_MEM_ADDR_W'(1);
                  if (next_idx_q == LAST_ADDR)
                     state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (drained) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Tag pipe runs alongside the memory read latency; its tail lines up with valid read data.
   always_ff @(posedge fgyrus_clk or negedge fgyrus_rst_n) begin
      if (!fgyrus_rst_n) begin
         for (int i = 0; i < RD_LATENCY; i++)
            tag_q[i] <= '0;
      end else begin
         tag_q[0] <= issue ? issue_tag : 4'b0000;
         for (int i = 1; i < RD_LATENCY; i++)
            tag_q[i] <= tag_q[i-1];
      end
   end

   assign push = tag_q[RD_LATENCY-1][3];
   assign pop  = !fifo_empty && pcm_if.pcm_ready;

   // Skid FIFO: entry = {lchnl, sop, eop, data}; cleared on reset so outputs read 0.
   always_ff @(posedge fgyrus_clk or negedge fgyrus_rst_n) begin
      if (!fgyrus_rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            fifo_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= {tag_q[RD_LATENCY-1][2:0], pcm_if.acortex2fgyrus_pcm_data};
            wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   // Next-state for completed-frame counter and sticky overrun (set beats clear).
   always_comb begin
      frame_cnt_d = frame_cnt_q + 16'(frame_done);
      overrun_d   = overrun_q;
      if (overrun_clr)
         overrun_d = 1'b0;
      if (rdy_pulse && busy_q)
         overrun_d = 1'b1;
   end

   // Status registers.
   always_ff @(posedge fgyrus_clk or negedge fgyrus_rst_n) begin
      if (!fgyrus_rst_n) begin
         frame_cnt_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         overrun_q   <= overrun_d;
      end
   end

   a_no_fifo_overflow: assert property (@(posedge fgyrus_clk) disable iff (!fgyrus_rst_n)
      !(push && !pop && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));

   assign head                       = fifo_q[rd_ptr_q];
   assign pcm_if.fgyrus2acortex_addr = addr_q;
   assign pcm_if.pcm_valid           = !fifo_empty;
   assign pcm_if.pcm_data            = head[PCM_MEM_DATA_W-1:0];
   assign pcm_if.pcm_eop             = head[PCM_MEM_DATA_W];
   assign pcm_if.pcm_sop             = head[PCM_MEM_DATA_W+1];
   assign pcm_if.pcm_lchnl           = head[PCM_MEM_DATA_W+2];
   assign busy                       = busy_q;
   assign frame_cnt                  = frame_cnt_q;
   assign overrun                    = overrun_q;
endmodule

// File: tb/tb_fgyrus_pcm_fetch.sv
// Bench for fgyrus_pcm_fetch: memory model, expected-frame queue, per-cycle stream checker.
module tb_fgyrus_pcm_fetch;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int NS = 128;
   localparam int RL = 2;
   localparam int FD = 4;
   localparam int NW = 2 * NS;

   logic        fgyrus_clk   = 1'b0;
   logic        fgyrus_rst_n = 1'b0;
   logic        fetch_en     = 1'b0;
   logic        pcm_rdy      = 1'b0;
   logic        overrun_clr  = 1'b0;
   logic        busy;
   logic [15:0] frame_cnt;
   logic        overrun;

   fgyrus_pcm_fetch_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   fgyrus_pcm_fetch #(
      .PCM_MEM_DATA_W(DW), .PCM_MEM_ADDR_W(AW), .NUM_SAMPLES(NS),
      .RD_LATENCY(RL), .FIFO_DEPTH(FD)
   ) dut (
      .fgyrus_clk            (fgyrus_clk),
      .fgyrus_rst_n          (fgyrus_rst_n),
      .fetch_en              (fetch_en),
      .acortex2fgyrus_pcm_rdy(pcm_rdy),
      .pcm_if                (bus),
      .busy                  (busy),
      .frame_cnt             (frame_cnt),
      .overrun               (overrun),
      .overrun_clr           (overrun_clr)
   );

   always #5 fgyrus_clk = ~fgyrus_clk;

   int cyc = 0;
   always @(posedge fgyrus_clk) cyc++;

   // Memory: address sampled on a clock edge, word visible RL edges after the address changed.
   logic [DW-1:0] rd_pipe [RL-1];
   always @(posedge fgyrus_clk) begin
      rd_pipe[0] <= 32'hA500_0000 | 32'(bus.fgyrus2acortex_addr);
      for (int i = 1; i < RL - 1; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.acortex2fgyrus_pcm_data = rd_pipe[RL-2];

   // Downstream ready: mode 0 = always ready, mode 1 = random ~30% duty.
   int rdy_mode = 0;
   initial begin
      bus.pcm_ready = 1'b0;
      forever begin
         @(posedge fgyrus_clk);
         #1;
         bus.pcm_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
      end
   end

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
      logic          s;
      logic          e;
   } beat_t;

   beat_t exp_q[$];
   int    n_chk  = 0;
   int    n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // A frame as the consumer must see it: word k = 0xA5000000|k, even k left, first sop, last eop.
   task automatic load_frame();
      beat_t b;
      for (int k = 0; k < NW; k++) begin
         b.d = 32'hA500_0000 | 32'(k);
         b.l = (k % 2 == 0);
         b.s = (k == 0);
         b.e = (k == NW - 1);
         exp_q.push_back(b);
      end
   endtask

   // Stream checker
   int    total_beats  = 0;
   int    sop_acc_cyc  = 0;
   int    last_eop_cyc = 0;
   beat_t last_b;
   logic  prev_stall   = 1'b0;
   logic [DW+2:0] prev_out;
   initial begin
      forever begin
         @(negedge fgyrus_clk);
         if (!fgyrus_rst_n) begin
            prev_stall = 1'b0;
         end else begin
            check("fifo_cnt_le_depth", 64'(dut.fifo_cnt_q <= FD), 64'd1);
            if (prev_stall)
               check("stall_stable", {bus.pcm_valid, bus.pcm_data, bus.pcm_lchnl, bus.pcm_sop, bus.pcm_eop},
                     {1'b1, prev_out});
            if (bus.pcm_valid) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_beat: got data %0h expected no beat (cycle %0d)", bus.pcm_data, cyc);
               end else begin
                  check("beat", {bus.pcm_data, bus.pcm_lchnl, bus.pcm_sop, bus.pcm_eop},
                        {exp_q[0].d, exp_q[0].l, exp_q[0].s, exp_q[0].e});
                  if (bus.pcm_ready) begin
                     if (exp_q[0].s) sop_acc_cyc = cyc;
                     if (exp_q[0].e) begin
                        last_eop_cyc = cyc;
                        last_b.d = bus.pcm_data;
                        last_b.l = bus.pcm_lchnl;
                        last_b.s = bus.pcm_sop;
                        last_b.e = bus.pcm_eop;
                     end
                     void'(exp_q.pop_front());
                     total_beats++;
                  end
               end
            end
            prev_stall = bus.pcm_valid && !bus.pcm_ready;
            prev_out   = {bus.pcm_data, bus.pcm_lchnl, bus.pcm_sop, bus.pcm_eop};
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge fgyrus_clk);
         #1;
      end
   endtask

   task automatic wait_busy(input string name, input logic val, input int budget);
      int n = 0;
      @(negedge fgyrus_clk);
      while (busy !== val && n < budget) begin
         @(negedge fgyrus_clk);
         n++;
      end
      check(name, 64'(busy), 64'(val));
   endtask

   task automatic run_frame(input string name);
      pcm_rdy = 1'b0;
      tick(4);
      load_frame();
      pcm_rdy = 1'b1;
      wait_busy({name, "_start"}, 1'b1, 20);
      wait_busy({name, "_end"}, 1'b0, 20000);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, n, b0;

      // Reset state
      @(negedge fgyrus_clk);
      check("rst_addr", 64'(bus.fgyrus2acortex_addr), 64'd0);
      check("rst_valid", 64'(bus.pcm_valid), 64'd0);
      check("rst_data", 64'(bus.pcm_data), 64'd0);
      check("rst_flags", {bus.pcm_lchnl, bus.pcm_sop, bus.pcm_eop}, 64'd0);
      check("rst_status", {busy, overrun, frame_cnt}, 64'd0);
      tick(1);
      fgyrus_rst_n = 1'b1;
      tick(5);

      // Basic frame, always ready
      fetch_en = 1'b1;
      rdy_mode = 0;
      load_frame();
      c0 = cyc;
      pcm_rdy = 1'b1;
      n = 0;
      @(negedge fgyrus_clk);
      while (!bus.pcm_valid && n < 20) begin
         @(negedge fgyrus_clk);
         n++;
      end
      check("first_valid_latency", 64'(cyc - c0), 64'd6);
      check("beat0_literal", {bus.pcm_data, bus.pcm_lchnl, bus.pcm_sop, bus.pcm_eop}, {32'hA500_0000, 3'b110});
      wait_busy("basic_end", 1'b0, 600);
      check("beat255_literal", {last_b.d, last_b.l, last_b.s, last_b.e}, {32'hA500_00FF, 3'b001});
      check("throughput", 64'(last_eop_cyc - sop_acc_cyc), 64'd255);
      check("busy_fall", 64'(cyc - last_eop_cyc), 64'd2);
      check("basic_frame_cnt", 64'(frame_cnt), 64'd1);
      check("basic_all_words", 64'(exp_q.size()), 64'd0);
      check("basic_last_addr", 64'(bus.fgyrus2acortex_addr), 64'hFF);

      // Backpressure
      rdy_mode = 1;
      run_frame("bp");
      rdy_mode = 0;
      check("bp_frame_cnt", 64'(frame_cnt), 64'd2);
      check("bp_all_words", 64'(exp_q.size()), 64'd0);
      check("bp_overrun", 64'(overrun), 64'd0);

      // Overrun: second rdy edge while word 100 is in flight
      pcm_rdy = 1'b0;
      tick(4);
      load_frame();
      pcm_rdy = 1'b1;
      wait_busy("ovr_start", 1'b1, 20);
      n = 0;
      while (bus.fgyrus2acortex_addr !== 8'd100 && n < 400) begin
         @(negedge fgyrus_clk);
         n++;
      end
      check("ovr_addr100", 64'(bus.fgyrus2acortex_addr), 64'd100);
      check("ovr_before", 64'(overrun), 64'd0);
      tick(1);
      pcm_rdy = 1'b0;
      tick(4);
      pcm_rdy = 1'b1;
      tick(6);
      check("ovr_set", {busy, overrun}, 64'b11);
      wait_busy("ovr_end", 1'b0, 600);
      check("ovr_frame_intact", 64'(exp_q.size()), 64'd0);
      check("ovr_frame_cnt", 64'(frame_cnt), 64'd3);
      tick(20);
      check("ovr_no_second_frame", {busy, frame_cnt}, {1'b0, 16'd3});
      check("ovr_sticky", 64'(overrun), 64'd1);
      overrun_clr = 1'b1;
      tick(1);
      overrun_clr = 1'b0;
      check("ovr_cleared", 64'(overrun), 64'd0);

      // Disabled
      fetch_en = 1'b0;
      pcm_rdy = 1'b0;
      tick(4);
      pcm_rdy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge fgyrus_clk);
         check("dis_addr", 64'(bus.fgyrus2acortex_addr), 64'hFF);
         check("dis_valid", 64'(bus.pcm_valid), 64'd0);
      end
      check("dis_status", {busy, overrun, frame_cnt}, {2'b00, 16'd3});

      // Reset mid-frame
      fetch_en = 1'b1;
      pcm_rdy = 1'b0;
      tick(4);
      load_frame();
      b0 = total_beats;
      pcm_rdy = 1'b1;
      n = 0;
      while (total_beats - b0 < 50 && n < 300) begin
         @(negedge fgyrus_clk);
         n++;
      end
      check("rstmid_beats", 64'(total_beats - b0), 64'd50);
      #2 fgyrus_rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("rstmid_addr", 64'(bus.fgyrus2acortex_addr), 64'd0);
      check("rstmid_stream", {bus.pcm_valid, bus.pcm_data, bus.pcm_lchnl, bus.pcm_sop, bus.pcm_eop}, 64'd0);
      check("rstmid_status", {busy, overrun, frame_cnt}, 64'd0);
      tick(3);
      fgyrus_rst_n = 1'b1;
      tick(10);
      check("rstmid_no_refetch", {busy, bus.pcm_valid}, 64'd0);
      run_frame("rstmid");
      check("rstmid_all_words", 64'(exp_q.size()), 64'd0);
      check("rstmid_frame_cnt", 64'(frame_cnt), 64'd1);

      // frame_cnt wrap
      @(negedge fgyrus_clk);
      force dut.frame_cnt_q = 16'hFFFF;
      @(posedge fgyrus_clk);
      @(negedge fgyrus_clk);
      release dut.frame_cnt_q;
      @(negedge fgyrus_clk);
      check("wrap_preload", 64'(frame_cnt), 64'hFFFF);
      run_frame("wrap");
      check("wrap_all_words", 64'(exp_q.size()), 64'd0);
      check("wrap_frame_cnt", 64'(frame_cnt), 64'd0);

      tick(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
